// File: rtl/mic_readout_scheduler.sv
// mic_readout_scheduler: walks the per-mic PCM FIFOs once per SPI frame.
// Each frame (ssel low) sends one header word, then SAMPLES_PER_FRAME rounds
// of one sample per mic, in mic order. All further requests return zero words.
module mic_readout_scheduler #(
    parameter int BIT_WIDTH         = 22,
    parameter int NUM_MICS          = 9,
    parameter int SAMPLES_PER_FRAME = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ssel,
    input  logic                          word_req,
    output logic [23:0]                   word_data,
    output logic                          word_valid,
    output logic [NUM_MICS-1:0]           fifo_rdreq,
    input  logic [NUM_MICS-1:0]           fifo_empty,
    input  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q,
    output logic                          frame_active,
    output logic [15:0]                   underrun_cnt,
    output logic                          req_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_FETCH,
        S_CAPT,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_MIC  = 5'(NUM_MICS - 1);
    localparam logic [7:0] LAST_SAMP = 8'(SAMPLES_PER_FRAME - 1);
    localparam logic [7:0] SPF_BYTE  = 8'(SAMPLES_PER_FRAME);

    state_t                state_reg;
    logic                  ssel_meta_reg, ssel_sync_reg, ssel_prev_reg;
    logic [4:0]            mic_idx_reg;
    logic [7:0]            samp_idx_reg;
    logic [7:0]            frame_seq_reg;
    logic                  empty_reg;      // selected FIFO was empty when the read was issued
    logic                  filler_reg;     // current capture is a post-frame zero word
    logic [23:0]           word_data_reg;
    logic                  word_valid_reg;
    logic [NUM_MICS-1:0]   rdreq_reg;
    logic                  frame_active_reg;
    logic [15:0]           underrun_reg;
    logic                  dropped_reg;

    logic                  ssel_fall, ssel_rise;
    logic [NUM_MICS-1:0]   mic_sel;
    logic [BIT_WIDTH-1:0]  fifo_slice [NUM_MICS];
    logic signed [BIT_WIDTH-1:0] sel_data;
    logic [23:0]           sel_sext;
    logic                  sel_empty;

    assign ssel_fall = ssel_prev_reg & ~ssel_sync_reg;
    assign ssel_rise = ~ssel_prev_reg & ssel_sync_reg;

    // Decode the current mic to a one-hot select and split the packed FIFO bus
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MICS; gi++) begin : g_mic
            assign mic_sel[gi]    = (mic_idx_reg == 5'(gi));
            assign fifo_slice[gi] = fifo_q[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    // AND-OR mux of the selected FIFO output
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_MICS; i++) begin
            if (mic_sel[i]) sel_data = fifo_slice[i];
        end
    end

    assign sel_sext  = 24'(sel_data);
    assign sel_empty = |(mic_sel & fifo_empty);

    // Bring the asynchronous ssel into the clk domain and keep a delayed copy for edges
    always_ff @(posedge clk) begin
        if (reset) begin
            ssel_meta_reg <= 1'b1;
            ssel_sync_reg <= 1'b1;
            ssel_prev_reg <= 1'b1;
        end else begin
            ssel_meta_reg <= ssel;
            ssel_sync_reg <= ssel_meta_reg;
            ssel_prev_reg <= ssel_sync_reg;
        end
    end

    // Frame sequencer: header, then request-driven FIFO reads, aborted by ssel rising
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            mic_idx_reg      <= '0;
            samp_idx_reg     <= '0;
            frame_seq_reg    <= '0;
            empty_reg        <= 1'b0;
            filler_reg       <= 1'b0;
            word_data_reg    <= '0;
            word_valid_reg   <= 1'b0;
            rdreq_reg        <= '0;
            frame_active_reg <= 1'b0;
            underrun_reg     <= '0;
            dropped_reg      <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            rdreq_reg      <= '0;
            if (state_reg != S_IDLE && ssel_rise) begin
                // Abort: any capture in flight is discarded
                state_reg        <= S_IDLE;
                frame_active_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (ssel_fall) begin
                            state_reg        <= S_HDR;
                            word_data_reg    <= {8'hA5, frame_seq_reg, SPF_BYTE};
                            word_valid_reg   <= 1'b1;
                            frame_active_reg <= 1'b1;
                            dropped_reg      <= 1'b0;
                            mic_idx_reg      <= '0;
                            samp_idx_reg     <= '0;
                        end
                    end
                    S_HDR: begin
                        if (word_req) dropped_reg <= 1'b1;
                        state_reg <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (word_req) begin
                            if (word_valid_reg) begin
                                dropped_reg <= 1'b1;
                            end else begin
                                state_reg  <= S_FETCH;
                                rdreq_reg  <= mic_sel & ~fifo_empty;
                                empty_reg  <= sel_empty;
                                filler_reg <= 1'b0;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (word_req) dropped_reg <= 1'b1;
                        state_reg <= S_CAPT;
                    end
                    S_CAPT: begin
                        if (word_req) dropped_reg <= 1'b1;
                        word_valid_reg <= 1'b1;
                        if (filler_reg) begin
                            word_data_reg <= '0;
                            state_reg     <= S_DONE;
                        end else begin
                            word_data_reg <= empty_reg ? 24'h0 : sel_sext;
                            if (empty_reg && underrun_reg != 16'hFFFF)
                                underrun_reg <= underrun_reg + 16'd1;
                            if (mic_idx_reg == LAST_MIC) begin
                                mic_idx_reg <= '0;
                                if (samp_idx_reg == LAST_SAMP) begin
                                    frame_seq_reg <= frame_seq_reg + 8'd1;
                                    state_reg     <= S_DONE;
                                end else begin
                                    samp_idx_reg <= samp_idx_reg + 8'd1;
                                    state_reg    <= S_WAIT;
                                end
                            end else begin
                                mic_idx_reg <= mic_idx_reg + 5'd1;
                                state_reg   <= S_WAIT;
                            end
                        end
                    end
                    S_DONE: begin
                        if (word_req) begin
                            if (word_valid_reg) begin
                                dropped_reg <= 1'b1;
                            end else begin
                                filler_reg <= 1'b1;
                                state_reg  <= S_CAPT;
                            end
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign word_data    = word_data_reg;
    assign word_valid   = word_valid_reg;
    // Drop the read strobe in the very cycle reset is applied so no FIFO word is consumed
    assign fifo_rdreq   = reset ? '0 : rdreq_reg;
    assign frame_active = frame_active_reg;
    assign underrun_cnt = underrun_reg;
    assign req_dropped  = dropped_reg;

endmodule

// File: tb/tb_mic_readout_scheduler.sv
// Testbench for mic_readout_scheduler: FIFO bank model, frame-level reference
// model feeding a scoreboard, and a single monitor that does all comparisons.
module tb_mic_readout_scheduler;

    localparam int BW  = 22;
    localparam int NM  = 9;
    localparam int SPF = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ssel = 1'b1;
    logic              word_req = 1'b0;
    logic [23:0]       word_data;
    logic              word_valid;
    logic [NM-1:0]     fifo_rdreq;
    logic [NM-1:0]     fifo_empty = '1;
    logic [NM*BW-1:0]  fifo_q;
    logic              frame_active;
    logic [15:0]       underrun_cnt;
    logic              req_dropped;

    mic_readout_scheduler #(
        .BIT_WIDTH(BW), .NUM_MICS(NM), .SAMPLES_PER_FRAME(SPF)
    ) dut (
        .clk(clk), .reset(reset), .ssel(ssel), .word_req(word_req),
        .word_data(word_data), .word_valid(word_valid),
        .fifo_rdreq(fifo_rdreq), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
        .frame_active(frame_active), .underrun_cnt(underrun_cnt),
        .req_dropped(req_dropped)
    );

    always #5 clk = ~clk;

    // FIFO bank: real contents (env_q) and the reference model's copy (model_q)
    int unsigned env_q   [NM][$];
    int unsigned model_q [NM][$];
    logic [BW-1:0] q_r [NM] = '{default: '0};
    int cyc = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_q
            assign fifo_q[gi*BW +: BW] = q_r[gi];
        end
    endgenerate

    // FIFO behaviour: data appears one cycle after rdreq, empty reflects contents
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NM; i++) begin
            if (fifo_rdreq[i] && env_q[i].size() != 0) q_r[i] <= BW'(env_q[i].pop_front());
            fifo_empty[i] <= (env_q[i].size() == 0);
        end
    end

    typedef struct { logic [23:0] data; int due; } exp_t;
    typedef struct { string name; int sig; int unsigned exp; } pc_t;
    exp_t exp_q[$];
    pc_t  pc_q[$];

    int k, seq, ucnt;
    bit done = 1'b0;
    int checks = 0, failures = 0;

    function automatic logic [23:0] sext(input int unsigned v);
        if (v >= (1 << (BW - 1))) return 24'(v + ((1 << 24) - (1 << BW)));
        return 24'(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic point(input string name, input int sig, input int unsigned expv);
        pc_t p;
        p.name = name; p.sig = sig; p.exp = expv;
        pc_q.push_back(p);
    endtask

    task automatic load(input int mic, input int unsigned v);
        env_q[mic].push_back(v);
        model_q[mic].push_back(v);
    endtask

    // Reference model for one accepted request issued in the current cycle
    task automatic predict();
        exp_t e;
        int mic;
        if (k < NM * SPF) begin
            mic = k % NM;
            e.due = cyc + 3;
            if (model_q[mic].size() == 0) begin
                e.data = 24'h0;
                if (ucnt < 65535) ucnt++;
            end else begin
                e.data = sext(model_q[mic].pop_front());
            end
            k++;
            if (k == NM * SPF) seq = (seq + 1) % 256;
        end else begin
            e.data = 24'h0;
            e.due  = cyc + 2;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue_req(input int gap);
        predict();
        word_req = 1'b1;
        tick(1);
        word_req = 1'b0;
        tick(gap - 1);
    endtask

    task automatic start_frame();
        exp_t e;
        ssel = 1'b1;
        tick(3);
        e.data = 24'(32'hA50000 + seq * 256 + SPF);
        e.due  = -1;
        exp_q.push_back(e);
        k = 0;
        ssel = 1'b0;
        tick(6);
        point("frame_active_hdr", 0, 1);
        point("req_dropped_hdr", 1, 0);
    endtask

    task automatic end_frame();
        tick(2);
        ssel = 1'b1;
        tick(5);
        point("frame_active_end", 0, 0);
        point("underrun_cnt", 2, ucnt);
        point("fifo_levels", 6, 0);
    endtask

    // Single monitor: scoreboard pops, point checks and read-strobe rules
    always @(negedge clk) begin
        exp_t e;
        pc_t  p;
        int unsigned act;
        if (word_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got=%06h at cycle %0d, none expected", word_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (word_data !== e.data || (e.due >= 0 && cyc != e.due)) begin
                    failures++;
                    $display("FAIL word got=%06h@%0d required=%06h@%0d", word_data, cyc, e.data, e.due);
                end
            end
        end
        if (fifo_rdreq != '0) begin
            checks++;
            act = 0;
            for (int i = 0; i < NM; i++)
                if (fifo_rdreq[i] && env_q[i].size() == 0) act++;
            if ($countones(fifo_rdreq) > 1 || act != 0) begin
                failures++;
                $display("FAIL rdreq_rule got=%b required=one-hot to non-empty FIFO", fifo_rdreq);
            end
        end
        while (pc_q.size() != 0) begin
            p = pc_q.pop_front();
            case (p.sig)
                0: act = 32'(frame_active);
                1: act = 32'(req_dropped);
                2: act = 32'(underrun_cnt);
                3: act = 32'(word_data);
                4: act = 32'(word_valid);
                5: act = 32'(fifo_rdreq);
                default: begin
                    act = 0;
                    for (int i = 0; i < NM; i++)
                        if (env_q[i].size() != model_q[i].size()) act++;
                end
            endcase
            checks++;
            if (act != p.exp) begin
                failures++;
                $display("FAIL %s got=%0h required=%0h", p.name, act, p.exp);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL missing_words got=%0d outstanding required=0", exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int n;
        k = 0; seq = 0; ucnt = 0;
        tick(3);
        point("rst_word_data", 3, 0);
        point("rst_word_valid", 4, 0);
        point("rst_rdreq", 5, 0);
        point("rst_frame_active", 0, 0);
        point("rst_underrun", 2, 0);
        point("rst_req_dropped", 1, 0);
        reset = 1'b0;
        tick(2);

        // Frame with every mic holding 0x100+i
        for (int s = 0; s < SPF; s++)
            for (int i = 0; i < NM; i++) load(i, 32'h100 + i);
        tick(2);
        start_frame();
        for (int r = 0; r < NM * SPF; r++) issue_req(8);
        end_frame();

        // Mic 3 empty, mic 0 full-scale negative; two filler words after the frame
        for (int s = 0; s < SPF; s++) begin
            load(0, 32'h3FFFFF);
            for (int i = 1; i < NM; i++)
                if (i != 3) load(i, $urandom & 32'h3FFFFF);
        end
        tick(2);
        start_frame();
        for (int r = 0; r < NM * SPF + 2; r++) issue_req(4 + $urandom_range(0, 4));
        end_frame();

        // Randomized occupancy and data
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NM; i++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) load(i, $urandom & 32'h3FFFFF);
            end
            tick(2);
            start_frame();
            n = $urandom_range(NM * SPF, NM * SPF + 2);
            for (int r = 0; r < n; r++) issue_req(4 + $urandom_range(0, 3));
            end_frame();
        end

        // Back-to-back requests: the second is dropped, only one read happens
        for (int i = 0; i < NM; i++) load(i, $urandom & 32'h3FFFFF);
        tick(2);
        start_frame();
        predict();
        word_req = 1'b1;
        tick(2);
        word_req = 1'b0;
        tick(6);
        point("req_dropped_set", 1, 1);
        issue_req(6);
        end_frame();

        // Abort with a read in flight: the sample is lost, frame_seq unchanged
        load(0, $urandom & 32'h3FFFFF);
        load(1, $urandom & 32'h3FFFFF);
        tick(2);
        start_frame();
        issue_req(6);
        if (model_q[k % NM].size() != 0) void'(model_q[k % NM].pop_front());
        word_req = 1'b1;
        ssel = 1'b1;
        tick(1);
        word_req = 1'b0;
        tick(6);
        point("abort_frame_active", 0, 0);
        point("abort_levels", 6, 0);
        start_frame();
        issue_req(6);
        end_frame();

        // Reset during FETCH: strobe gated immediately, everything cleared
        load(0, $urandom & 32'h3FFFFF);
        tick(2);
        start_frame();
        word_req = 1'b1;
        tick(1);
        word_req = 1'b0;
        reset = 1'b1;
        ssel = 1'b1;
        point("rst_fetch_rdreq", 5, 0);
        tick(1);
        point("rst2_word_data", 3, 0);
        point("rst2_word_valid", 4, 0);
        point("rst2_frame_active", 0, 0);
        point("rst2_underrun", 2, 0);
        point("rst2_req_dropped", 1, 0);
        seq = 0; ucnt = 0;
        tick(1);
        reset = 1'b0;
        tick(2);
        start_frame();
        issue_req(6);
        end_frame();

        tick(5);
        done = 1'b1;
    end

endmodule

// File: doc/mic_readout_scheduler.md
Name: mic_readout_scheduler

Overview:
- Sequences readout of the per-microphone PCM sample FIFOs onto the SPI slave's transmit word.
- Each SPI transaction (ssel low) is one frame: a header word, then SAMPLES_PER_FRAME rounds of one sample per mic, in mic order 0..NUM_MICS-1.
- Sits between the FIFO bank (CIC write side) and the spi_slave dataToSend/dataNeeded interface; replaces ad-hoc mic counting in the top level.

Parameters:
- BIT_WIDTH, 22, PCM sample width; must be <=24.
- NUM_MICS, 9, number of mic FIFOs; must be 2..31.
- SAMPLES_PER_FRAME, 4, samples read per mic per frame; must be 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ssel  in  1  raw SPI slave select, asynchronous, active low
- word_req  in  1  single-cycle pulse (clk domain): SPI slave needs next word
- word_data  out  24  word to transmit
- word_valid  out  1  one-cycle pulse when word_data updates
- fifo_rdreq  out  NUM_MICS  per-FIFO read request, one-hot or zero
- fifo_empty  in  NUM_MICS  per-FIFO empty flag
- fifo_q  in  NUM_MICS*BIT_WIDTH  FIFO outputs, mic i at [i*BIT_WIDTH +: BIT_WIDTH]; data valid 1 cycle after rdreq
- frame_active  out  1  high from header presentation until IDLE
- underrun_cnt  out  16  saturating count of words zero-filled due to empty FIFO
- req_dropped  out  1  sticky: word_req arrived while busy; cleared at frame start

Behaviour:
- Reset: state IDLE; word_data=0, word_valid=0, fifo_rdreq=0, frame_active=0, underrun_cnt=0, req_dropped=0, frame_seq=0, mic_idx=0, samp_idx=0. ssel synchronizer flops reset to 1.
- ssel passes through a 2-flop synchronizer plus an edge register. Falls/rises are detected on the synchronized signal.
- States:
  - IDLE: wait for a synchronized ssel falling edge.
  - HDR: present the header.
  - WAIT: wait for word_req.
  - FETCH: rdreq issued.
  - CAPT: capture fifo_q.
  - DONE: sample words exhausted.
- Falling edge (IDLE only) -> HDR.
  - HDR (1 cycle): word_data={8'hA5, frame_seq, SAMPLES_PER_FRAME[7:0]}; word_valid=1; frame_active=1; req_dropped cleared; mic_idx=samp_idx=0; -> WAIT.
- WAIT + word_req -> FETCH.
  - fifo_rdreq[mic_idx]=~fifo_empty[mic_idx] for exactly this one cycle.
  - Record empty flag.
- FETCH -> CAPT, which registers fifo_q slice.
  - The next cycle's word_data is the sign-extended sample, or 24'h0 if the empty flag was recorded. An empty also increments underrun_cnt, saturating at 16'hFFFF.
  - word_valid=1 in that cycle.
  - Latency: word_valid exactly 3 cycles after word_req.
- After each sample word, mic_idx increments. At NUM_MICS-1 it wraps to 0 and samp_idx increments.
  - After the word with mic_idx=NUM_MICS-1 and samp_idx=SAMPLES_PER_FRAME-1: frame_seq increments mod 256 -> DONE; otherwise -> WAIT.
- DONE + word_req: word_data=0, word_valid=1 two cycles later, no rdreq, no underrun count.
- word_req while in HDR/FETCH/CAPT (or in the word_valid cycle of a sample word): ignored, req_dropped=1.
- Synchronized ssel rising edge in any non-IDLE state -> IDLE next cycle.
  - fifo_rdreq forced 0 and frame_active=0; any pending capture is discarded (that FIFO sample is lost); no word_valid.
  - frame_seq is not incremented unless DONE was reached.
- Simultaneous ssel rising edge and word_req: abort wins.
- Falling edge while not IDLE: impossible without an intervening rise; ignored.
- reset mid-frame: all state returns to reset values next cycle; rdreq deasserted same cycle reset is sampled.
- fifo_rdreq never has more than one bit set; never set for an empty FIFO.

Test Plan:
- Reset, fifos all non-empty with mic i holding 22'h000100+i, SAMPLES_PER_FRAME=1. ssel low, then 9 word_req pulses spaced 8 cycles -> header 24'hA50001, then words 24'h000100..24'h000108 in order, each word_valid 3 cycles after its req. underrun_cnt=0, frame_seq then 1.
- Mic 3 FIFO empty, mic 0 holds 22'h3FFFFF -> mic0 word 24'hFFFFFF (sign-extended), mic3 word 24'h000000. fifo_rdreq[3] never asserted; underrun_cnt=1.
- After full frame, 2 extra word_req -> two 24'h000000 words, no rdreq; next frame header 24'hA50101.
- word_req pulses on consecutive cycles -> second dropped, req_dropped=1. Exactly one FIFO read; req_dropped clears at next header.
- ssel rises in the cycle after an rdreq -> no word_valid, state IDLE, frame_active=0, frame_seq unchanged. Next frame header still carries the old frame_seq.
- reset asserted in the FETCH cycle -> all outputs 0 next cycle; subsequent ssel fall gives header 24'hA50001.
